// File: rtl/csi_rx_frame_tracker.sv
// -----------------------------------------------------------------------------
// csi_rx_frame_tracker
//
// Follows CSI-2 frame/line structure from the packet parser outputs (byte-clock
// domain). FS/FE short packets open and close a frame. Each long-packet header
// is one line. Its payload is trimmed to the header word count and re-emitted
// as byte-enabled pixel beats with SOF/SOL/EOL markers. Sequence, word-count
// and line-count errors are sticky, and each cycle that has at least one
// error adds one to a saturating counter.
//
// Optional feature: define CSI_RX_FRAME_TRACKER_VC_FILTER_EN to track only
// virtual channel VC_ID. Other headers, and payload that follows a rejected
// long header, are dropped silently.
//
// Ports
//   clk_byte_i, reset_byte_n_i     byte clock, async active-low reset
//   sp_en_i / lp_en_i              short / long header strobes
//   dt_i, vc_i, wc_i               header fields
//   payload_en_i, payload_i        32-bit payload beats, byte 0 in [7:0]
//   err_clr_i                      clears sticky errors and the error counter
//   frame_active_o, line_cnt_o,
//   frame_cnt_o                    frame/line tracking
//   pix_*                          registered pixel beats, 1-cycle latency
//   err_seq_o, err_wc_o,
//   err_lines_o, err_cnt_o         error reporting
// -----------------------------------------------------------------------------
module csi_rx_frame_tracker #(
    parameter int         EXP_LINES = 0,
    parameter logic [1:0] VC_ID     = 2'd0,
    parameter int         ERR_CNT_W = 8
) (
    input  logic                 clk_byte_i,
    input  logic                 reset_byte_n_i,
    input  logic                 sp_en_i,
    input  logic                 lp_en_i,
    input  logic [5:0]           dt_i,
    input  logic [1:0]           vc_i,
    input  logic [15:0]          wc_i,
    input  logic                 payload_en_i,
    input  logic [31:0]          payload_i,
    input  logic                 err_clr_i,
    output logic                 frame_active_o,
    output logic [15:0]          line_cnt_o,
    output logic [15:0]          frame_cnt_o,
    output logic                 pix_valid_o,
    output logic [31:0]          pix_data_o,
    output logic [3:0]           pix_be_o,
    output logic                 pix_sof_o,
    output logic                 pix_sol_o,
    output logic                 pix_eol_o,
    output logic                 err_seq_o,
    output logic                 err_wc_o,
    output logic                 err_lines_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } state_e;

    localparam logic [5:0]  DT_FS       = 6'h00;
    localparam logic [5:0]  DT_FE       = 6'h01;
    localparam logic [15:0] EXP_LINES_W = 16'(EXP_LINES);

    // Byte enables for the last beat of a line holding 1..4 remaining bytes
    function automatic logic [3:0] tail_be(input logic [2:0] n);
        logic [3:0] be;
        case (n)
            3'd1:    be = 4'b0001;
            3'd2:    be = 4'b0011;
            3'd3:    be = 4'b0111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    state_e                 state_q, state_d;
    logic [15:0]            rem_q, rem_d;
    logic                   first_line_q, first_line_d;
    logic                   line_start_q, line_start_d;
    logic                   skip_q, skip_d;
    logic                   frame_active_q, frame_active_d;
    logic [15:0]            line_cnt_q, line_cnt_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [31:0]            pix_data_q, pix_data_d;
    logic [3:0]             pix_be_q, pix_be_d;
    logic                   pix_sof_q, pix_sof_d;
    logic                   pix_sol_q, pix_sol_d;
    logic                   pix_eol_q, pix_eol_d;
    logic                   err_seq_q, err_seq_d;
    logic                   err_wc_q, err_wc_d;
    logic                   err_lines_q, err_lines_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic hdr_ok_s;
    logic is_fs_s;
    logic is_fe_s;
    logic ev_seq_s;
    logic ev_wc_s;
    logic ev_lines_s;

`ifdef CSI_RX_FRAME_TRACKER_VC_FILTER_EN
    assign hdr_ok_s = (vc_i == VC_ID);
`else
    logic unused_vc_s;
    assign unused_vc_s = ^{vc_i, VC_ID};
    assign hdr_ok_s    = 1'b1;
`endif

    assign is_fs_s = sp_en_i & (dt_i == DT_FS);
    assign is_fe_s = sp_en_i & (dt_i == DT_FE);

    // Next-state: payload beat is applied first, then any header in the same cycle
    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        first_line_d   = first_line_q;
        line_start_d   = line_start_q;
        skip_d         = skip_q;
        frame_active_d = frame_active_q;
        line_cnt_d     = line_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        pix_valid_d    = 1'b0;
        pix_data_d     = 32'd0;
        pix_be_d       = 4'd0;
        pix_sof_d      = 1'b0;
        pix_sol_d      = 1'b0;
        pix_eol_d      = 1'b0;
        ev_seq_s       = 1'b0;
        ev_wc_s        = 1'b0;
        ev_lines_s     = 1'b0;

        // Payload beat (skipped while following a filtered long header)
        if (payload_en_i && !skip_q) begin
            if (state_q == ST_LINE) begin
                pix_valid_d  = 1'b1;
                pix_data_d   = payload_i;
                pix_sol_d    = line_start_q;
                pix_sof_d    = line_start_q & first_line_q;
                line_start_d = 1'b0;
                if (line_start_q) begin
                    first_line_d = 1'b0;
                end else begin
                    first_line_d = first_line_q;
                end
                if (rem_q > 16'd4) begin
                    pix_be_d = 4'b1111;
                    rem_d    = rem_q - 16'd4;
                end else begin
                    pix_be_d  = tail_be(rem_q[2:0]);
                    pix_eol_d = 1'b1;
                    rem_d     = 16'd0;
                    state_d   = ST_FRAME;
                end
            end else begin
                ev_wc_s = 1'b1;
            end
        end else begin
            ev_wc_s = 1'b0;
        end

        // Header handling, using the state left behind by the beat above
        if ((sp_en_i || lp_en_i) && hdr_ok_s) begin
            skip_d = 1'b0;
            // A header inside an unfinished line truncates it without EOL
            if (state_d == ST_LINE) begin
                ev_wc_s      = 1'b1;
                rem_d        = 16'd0;
                line_start_d = 1'b0;
                state_d      = ST_FRAME;
            end else begin
                rem_d = rem_d;
            end
            case (state_d)
                ST_IDLE: begin
                    if (lp_en_i || is_fe_s) begin
                        ev_seq_s = 1'b1;
                    end else if (is_fs_s) begin
                        state_d        = ST_FRAME;
                        frame_active_d = 1'b1;
                        line_cnt_d     = 16'd0;
                        first_line_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (lp_en_i) begin
                        line_cnt_d = line_cnt_q + 16'd1;
                        if (wc_i != 16'd0) begin
                            state_d      = ST_LINE;
                            rem_d        = wc_i;
                            line_start_d = 1'b1;
                        end else begin
                            state_d = ST_FRAME;
                        end
                    end else if (is_fs_s) begin
                        ev_seq_s   = 1'b1;
                        line_cnt_d = 16'd0;
                    end else if (is_fe_s) begin
                        state_d        = ST_IDLE;
                        frame_active_d = 1'b0;
                        frame_cnt_d    = frame_cnt_q + 16'd1;
                        if ((EXP_LINES_W != 16'd0) && (line_cnt_q != EXP_LINES_W)) begin
                            ev_lines_s = 1'b1;
                        end else begin
                            ev_lines_s = 1'b0;
                        end
                    end else begin
                        state_d = ST_FRAME;
                    end
                end
            endcase
        end else if (lp_en_i) begin
            // Rejected long header: its payload must be dropped too
            skip_d = 1'b1;
        end else begin
            skip_d = skip_d;
        end

        // Sticky flags and the saturating counter; a new error beats a clear
        if (err_clr_i) begin
            err_seq_d   = ev_seq_s;
            err_wc_d    = ev_wc_s;
            err_lines_d = ev_lines_s;
            err_cnt_d   = (ev_seq_s | ev_wc_s | ev_lines_s) ? ERR_CNT_W'(1) : '0;
        end else begin
            err_seq_d   = err_seq_q | ev_seq_s;
            err_wc_d    = err_wc_q | ev_wc_s;
            err_lines_d = err_lines_q | ev_lines_s;
            if ((ev_seq_s | ev_wc_s | ev_lines_s) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_byte_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i) begin
            state_q        <= ST_IDLE;
            rem_q          <= 16'd0;
            first_line_q   <= 1'b1;
            line_start_q   <= 1'b0;
            skip_q         <= 1'b0;
            frame_active_q <= 1'b0;
            line_cnt_q     <= 16'd0;
            frame_cnt_q    <= 16'd0;
            pix_valid_q    <= 1'b0;
            pix_data_q     <= 32'd0;
            pix_be_q       <= 4'd0;
            pix_sof_q      <= 1'b0;
            pix_sol_q      <= 1'b0;
            pix_eol_q      <= 1'b0;
            err_seq_q      <= 1'b0;
            err_wc_q       <= 1'b0;
            err_lines_q    <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            first_line_q   <= first_line_d;
            line_start_q   <= line_start_d;
            skip_q         <= skip_d;
            frame_active_q <= frame_active_d;
            line_cnt_q     <= line_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            pix_valid_q    <= pix_valid_d;
            pix_data_q     <= pix_data_d;
            pix_be_q       <= pix_be_d;
            pix_sof_q      <= pix_sof_d;
            pix_sol_q      <= pix_sol_d;
            pix_eol_q      <= pix_eol_d;
            err_seq_q      <= err_seq_d;
            err_wc_q       <= err_wc_d;
            err_lines_q    <= err_lines_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign frame_active_o = frame_active_q;
    assign line_cnt_o     = line_cnt_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign pix_valid_o    = pix_valid_q;
    assign pix_data_o     = pix_data_q;
    assign pix_be_o       = pix_be_q;
    assign pix_sof_o      = pix_sof_q;
    assign pix_sol_o      = pix_sol_q;
    assign pix_eol_o      = pix_eol_q;
    assign err_seq_o      = err_seq_q;
    assign err_wc_o       = err_wc_q;
    assign err_lines_o    = err_lines_q;
    assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_csi_rx_frame_tracker.sv
// -----------------------------------------------------------------------------
// Testbench for csi_rx_frame_tracker. There are two instances:
//   u0: default parameters.
//   u1: EXP_LINES=3, ERR_CNT_W=2.
// Both instances receive the same stimulus. A reference model expresses the
// tracker in terms of frames, lines and remaining byte budgets. The stimulus
// is directed scenarios first, then a randomized packet stream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csi_rx_frame_tracker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sp_en, lp_en, pe, clr;
    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;
    logic [31:0] pl;

    logic        fa[2];
    logic [15:0] lc[2];
    logic [15:0] fc[2];
    logic        pv[2];
    logic [31:0] pd[2];
    logic [3:0]  pb[2];
    logic        sof[2], sol[2], eol[2], es[2], ew[2], el[2];
    logic [7:0]  ec0;
    logic [1:0]  ec1;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int exp_lines[2] = '{0, 3};
    int cnt_max[2]   = '{255, 3};
    int m_infr[2], m_rem[2], m_newl[2], m_first[2], m_skip[2];
    int m_lines[2], m_frames[2], m_es[2], m_ew[2], m_el[2], m_cnt[2];
    int x_pv[2], x_be[2], x_sof[2], x_sol[2], x_eol[2];
    logic [31:0] x_pd[2];

    // Random stimulus scratch
    int          r;
    logic        r_sp, r_lp, r_pe, r_clr;
    logic [5:0]  r_dt;
    logic [1:0]  r_vc;
    logic [15:0] r_wc;

    always #5 clk = ~clk;

    csi_rx_frame_tracker u0 (
        .clk_byte_i(clk), .reset_byte_n_i(rst_n), .sp_en_i(sp_en), .lp_en_i(lp_en),
        .dt_i(dt), .vc_i(vc), .wc_i(wc), .payload_en_i(pe), .payload_i(pl), .err_clr_i(clr),
        .frame_active_o(fa[0]), .line_cnt_o(lc[0]), .frame_cnt_o(fc[0]),
        .pix_valid_o(pv[0]), .pix_data_o(pd[0]), .pix_be_o(pb[0]),
        .pix_sof_o(sof[0]), .pix_sol_o(sol[0]), .pix_eol_o(eol[0]),
        .err_seq_o(es[0]), .err_wc_o(ew[0]), .err_lines_o(el[0]), .err_cnt_o(ec0)
    );

    csi_rx_frame_tracker #(.EXP_LINES(3), .ERR_CNT_W(2)) u1 (
        .clk_byte_i(clk), .reset_byte_n_i(rst_n), .sp_en_i(sp_en), .lp_en_i(lp_en),
        .dt_i(dt), .vc_i(vc), .wc_i(wc), .payload_en_i(pe), .payload_i(pl), .err_clr_i(clr),
        .frame_active_o(fa[1]), .line_cnt_o(lc[1]), .frame_cnt_o(fc[1]),
        .pix_valid_o(pv[1]), .pix_data_o(pd[1]), .pix_be_o(pb[1]),
        .pix_sof_o(sof[1]), .pix_sol_o(sol[1]), .pix_eol_o(eol[1]),
        .err_seq_o(es[1]), .err_wc_o(ew[1]), .err_lines_o(el[1]), .err_cnt_o(ec1)
    );

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_infr[i] = 0; m_rem[i] = 0; m_newl[i] = 0; m_first[i] = 1; m_skip[i] = 0;
            m_lines[i] = 0; m_frames[i] = 0; m_es[i] = 0; m_ew[i] = 0; m_el[i] = 0; m_cnt[i] = 0;
            x_pv[i] = 0; x_pd[i] = 32'd0; x_be[i] = 0; x_sof[i] = 0; x_sol[i] = 0; x_eol[i] = 0;
        end
    endtask

    // One byte-clock cycle of the tracker, described in frame/line terms
    task automatic model_step();
        int n, e_seq, e_wc, e_lines, acc;
        for (int i = 0; i < 2; i++) begin
            e_seq = 0; e_wc = 0; e_lines = 0;
            x_pv[i] = 0; x_pd[i] = 32'd0; x_be[i] = 0; x_sof[i] = 0; x_sol[i] = 0; x_eol[i] = 0;
            acc = 1;
`ifdef CSI_RX_FRAME_TRACKER_VC_FILTER_EN
            acc = (vc == 2'd0) ? 1 : 0;
`endif
            if (pe && m_skip[i] == 0) begin
                if (m_rem[i] > 0) begin
                    n = (m_rem[i] < 4) ? m_rem[i] : 4;
                    x_pv[i] = 1; x_pd[i] = pl; x_be[i] = (1 << n) - 1;
                    x_sol[i] = m_newl[i];
                    x_sof[i] = m_newl[i] & m_first[i];
                    if (m_newl[i] != 0) m_first[i] = 0;
                    m_newl[i] = 0;
                    x_eol[i] = (m_rem[i] <= 4) ? 1 : 0;
                    m_rem[i] -= n;
                end else begin
                    e_wc = 1;
                end
            end
            if (sp_en || lp_en) begin
                if (acc == 0) begin
                    if (lp_en) m_skip[i] = 1;
                end else begin
                    m_skip[i] = 0;
                    if (m_rem[i] > 0) begin
                        e_wc = 1; m_rem[i] = 0; m_newl[i] = 0;
                    end
                    if (m_infr[i] == 0) begin
                        if (lp_en || (sp_en && dt == 6'h01)) e_seq = 1;
                        else if (sp_en && dt == 6'h00) begin
                            m_infr[i] = 1; m_lines[i] = 0; m_first[i] = 1;
                        end
                    end else if (lp_en) begin
                        m_lines[i] = (m_lines[i] + 1) % 65536;
                        if (wc != 16'd0) begin m_rem[i] = int'(wc); m_newl[i] = 1; end
                    end else if (dt == 6'h00) begin
                        e_seq = 1; m_lines[i] = 0;
                    end else if (dt == 6'h01) begin
                        m_infr[i] = 0;
                        m_frames[i] = (m_frames[i] + 1) % 65536;
                        if (exp_lines[i] != 0 && m_lines[i] != exp_lines[i]) e_lines = 1;
                    end
                end
            end
            if (clr) begin
                m_es[i] = e_seq; m_ew[i] = e_wc; m_el[i] = e_lines;
                m_cnt[i] = (e_seq | e_wc | e_lines) ? 1 : 0;
            end else begin
                m_es[i] |= e_seq; m_ew[i] |= e_wc; m_el[i] |= e_lines;
                if ((e_seq | e_wc | e_lines) != 0 && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("frame_active", i, 32'(fa[i]), 32'(m_infr[i]));
            chk("line_cnt", i, 32'(lc[i]), 32'(m_lines[i]));
            chk("frame_cnt", i, 32'(fc[i]), 32'(m_frames[i]));
            chk("pix_valid", i, 32'(pv[i]), 32'(x_pv[i]));
            chk("pix_data", i, pd[i], x_pd[i]);
            chk("pix_be", i, 32'(pb[i]), 32'(x_be[i]));
            chk("pix_sof", i, 32'(sof[i]), 32'(x_sof[i]));
            chk("pix_sol", i, 32'(sol[i]), 32'(x_sol[i]));
            chk("pix_eol", i, 32'(eol[i]), 32'(x_eol[i]));
            chk("err_seq", i, 32'(es[i]), 32'(m_es[i]));
            chk("err_wc", i, 32'(ew[i]), 32'(m_ew[i]));
            chk("err_lines", i, 32'(el[i]), 32'(m_el[i]));
            chk("err_cnt", i, (i == 0) ? 32'(ec0) : 32'(ec1), 32'(m_cnt[i]));
        end
    endtask

    task automatic step(input logic s, input logic l, input logic [5:0] d, input logic [1:0] v,
                        input logic [15:0] w, input logic p, input logic [31:0] data, input logic c);
        sp_en = s; lp_en = l; dt = d; vc = v; wc = w; pe = p; pl = data; clr = c;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();        step(1'b0, 1'b0, 6'h00, 2'd0, 16'd0, 1'b0, 32'd0, 1'b0); endtask
    task automatic fs();          step(1'b1, 1'b0, 6'h00, 2'd0, 16'd0, 1'b0, 32'd0, 1'b0); endtask
    task automatic fe();          step(1'b1, 1'b0, 6'h01, 2'd0, 16'd0, 1'b0, 32'd0, 1'b0); endtask
    task automatic lp(input logic [15:0] w); step(1'b0, 1'b1, 6'h2b, 2'd0, w, 1'b0, 32'd0, 1'b0); endtask
    task automatic beat();        step(1'b0, 1'b0, 6'h00, 2'd0, 16'd0, 1'b1, $urandom, 1'b0); endtask
    task automatic eclr();        step(1'b0, 1'b0, 6'h00, 2'd0, 16'd0, 1'b0, 32'd0, 1'b1); endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sp_en = 1'b0; lp_en = 1'b0; dt = 6'h00; vc = 2'd0; wc = 16'd0; pe = 1'b0; pl = 32'd0; clr = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        sp_en = 1'b0; lp_en = 1'b0; dt = 6'h00; vc = 2'd0; wc = 16'd0; pe = 1'b0; pl = 32'd0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Basic frame: one line of 8 bytes in two full beats
        fs(); lp(16'd8);
        beat(); chk("t1_sof", 0, 32'(sof[0]), 32'd1); chk("t1_be1", 0, 32'(pb[0]), 32'hF);
        beat(); chk("t1_eol", 0, 32'(eol[0]), 32'd1); chk("t1_be2", 0, 32'(pb[0]), 32'hF);
        fe();   chk("t1_lines", 0, 32'(lc[0]), 32'd1); chk("t1_frames", 0, 32'(fc[0]), 32'd1);
        chk("t1_errcnt", 0, 32'(ec0), 32'd0);

        // Partial last beat followed by a stray beat
        fs(); lp(16'd6); beat();
        beat(); chk("t2_be", 0, 32'(pb[0]), 32'h3); chk("t2_eol", 0, 32'(eol[0]), 32'd1);
        beat(); chk("t2_errwc", 0, 32'(ew[0]), 32'd1); chk("t2_errcnt", 0, 32'(ec0), 32'd1);
        chk("t2_nopix", 0, 32'(pv[0]), 32'd0);
        fe();

        // Sequence errors: FE while idle, then a repeated FS
        eclr(); fe(); fs(); lp(16'd0);
        step(1'b1, 1'b0, 6'h08, 2'd0, 16'd0, 1'b0, 32'd0, 1'b0);   // other short type: ignored
        fs();   chk("t3_errseq", 0, 32'(es[0]), 32'd1); chk("t3_errcnt", 0, 32'(ec0), 32'd2);
        chk("t3_lines", 0, 32'(lc[0]), 32'd0);
        fe();

        // Line-count check on u1 (expects 3 lines)
        eclr(); fs(); lp(16'd4); beat(); lp(16'd4); beat();
        fe();   chk("t4_errlines", 1, 32'(el[1]), 32'd1);

        // New header truncates an unfinished line
        eclr(); fs(); lp(16'd12);
        beat(); chk("t5_noeol", 0, 32'(eol[0]), 32'd0);
        lp(16'd8); chk("t5_errwc", 0, 32'(ew[0]), 32'd1); chk("t5_lines", 0, 32'(lc[0]), 32'd2);
        beat(); chk("t5_sol", 0, 32'(sol[0]), 32'd1);
        beat(); fe();

        // Beat and header in the same cycle: beat applied first
        fs(); lp(16'd4);
        step(1'b0, 1'b1, 6'h2b, 2'd0, 16'd5, 1'b1, 32'hA5A5_0001, 1'b0);
        beat(); beat();
        step(1'b1, 1'b0, 6'h01, 2'd0, 16'd0, 1'b1, 32'hA5A5_0002, 1'b0);

        // Saturation on u1, then clear racing a new error, then plain clear
        eclr();
        for (int k = 0; k < 5; k++) beat();
        chk("t6_sat", 1, 32'(ec1), 32'd3);
        step(1'b0, 1'b0, 6'h00, 2'd0, 16'd0, 1'b1, 32'd1, 1'b1);
        chk("t6_clrwin", 1, 32'(ec1), 32'd1);
        eclr(); chk("t6_clr", 1, 32'(ec1), 32'd0); chk("t6_clrwc", 0, 32'(ew[0]), 32'd0);

        // Reset in the middle of a line
        fs(); lp(16'd12); beat();
        do_reset();
        beat(); idle();

        // A frame on virtual channel 1 (dropped when the VC filter is built in)
        step(1'b1, 1'b0, 6'h00, 2'd1, 16'd0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 6'h2b, 2'd1, 16'd8, 1'b0, 32'd0, 1'b0);
        beat(); beat();
        step(1'b1, 1'b0, 6'h01, 2'd1, 16'd0, 1'b0, 32'd0, 1'b0);
        eclr();

        // Randomized packet stream
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            r_sp = 1'b0; r_lp = 1'b0; r_dt = 6'h2b; r_wc = 16'd0;
            if (r < 8) begin
                r_lp = 1'b1; r_wc = 16'($urandom_range(0, 16));
            end else if (r < 11) begin
                r_sp = 1'b1; r_dt = 6'h00;
            end else if (r < 15) begin
                r_sp = 1'b1; r_dt = 6'h01;
            end else begin
                r_sp = 1'b0;
            end
            r_pe  = ($urandom_range(0, 99) < 65);
            r_clr = ($urandom_range(0, 99) < 2);
            r_vc  = ($urandom_range(0, 9) == 0) ? 2'd1 : 2'd0;
            step(r_sp, r_lp, r_dt, r_vc, r_wc, r_pe, $urandom, r_clr);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csi_rx_frame_tracker.md
Name: csi_rx_frame_tracker

Overview:
- Sits directly downstream of the CSI-2 RX packet parser and consumes its short-packet, long-packet header and 32-bit payload outputs in the byte-clock domain.
- Tracks frame and line structure from the FS/FE short packets and the long-packet headers.
- Trims payload to the header word count and emits byte-enabled pixel beats with SOF/SOL/EOL markers.
- Flags sequence, word-count and line-count errors, with a saturating error counter.

Parameters:
EXP_LINES, 0, expected long packets per frame; 0 disables the line-count check
VC_ID, 0, virtual channel accepted when the VC filter is compiled in
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk_byte_i  input  1  byte clock, same clock as the parser outputs
reset_byte_n_i  input  1  asynchronous active-low reset
sp_en_i  input  1  short-packet header valid, one-cycle pulse
lp_en_i  input  1  long-packet header valid, one-cycle pulse
dt_i  input  6  data type, valid with sp_en_i/lp_en_i
vc_i  input  2  virtual channel, valid with sp_en_i/lp_en_i
wc_i  input  16  word count in bytes (long) or data field (short)
payload_en_i  input  1  payload beat valid
payload_i  input  32  payload beat, byte 0 in bits [7:0]
err_clr_i  input  1  synchronous clear of sticky errors and error counter
frame_active_o  output  1  high between accepted FS and FE
line_cnt_o  output  16  long packets seen in the current frame
frame_cnt_o  output  16  completed frames, wraps at 0xFFFF->0
pix_valid_o  output  1  pixel beat valid
pix_data_o  output  32  pixel beat data
pix_be_o  output  4  byte enables for pix_data_o
pix_sof_o  output  1  first beat of the first line of a frame
pix_sol_o  output  1  first beat of a line
pix_eol_o  output  1  last beat of a line
err_seq_o  output  1  sticky sequence error
err_wc_o  output  1  sticky word-count error
err_lines_o  output  1  sticky line-count error
err_cnt_o  output  ERR_CNT_W  saturating count of error events

Behaviour:
- Reset: all outputs 0, state IDLE, remaining-byte counter 0, first-line flag set.
- Reset asserted mid-packet aborts the packet immediately; no EOL is emitted.
- Short data types: FS=0x00, FE=0x01. Other short packets are ignored.
- A long packet is any lp_en_i header; its byte budget is rem = wc_i.
- States:
  - IDLE: FS -> FRAME; frame_active_o=1; line_cnt_o=0; first-line flag set. FE or lp_en_i -> err_seq, stay IDLE. Payload -> err_wc, beat dropped.
  - FRAME: lp_en_i -> line_cnt_o+1; if wc_i>0 go to LINE with rem=wc_i, else stay (zero-length line, no pixel output). FE -> IDLE; frame_active_o=0; frame_cnt_o+1; if EXP_LINES!=0 and line_cnt_o!=EXP_LINES -> err_lines. FS -> err_seq, line_cnt_o restarts at 0. Payload -> err_wc, beat dropped.
  - LINE: each payload beat outputs 1 cycle later with pix_valid_o=1.
    - pix_be_o = 4'b1111 if rem>4, else low rem bits set (1->0001, 2->0011, 3->0111, 4->1111); rem -= min(rem,4).
    - pix_sol_o on the first beat of the line; pix_sof_o also set if the first-line flag is set (flag then clears).
    - pix_eol_o when rem<=4; next state FRAME.
    - Any sp_en_i/lp_en_i while rem>0 -> err_wc; line truncated without EOL; header then processed as in FRAME.
- Simultaneous payload beat and header in one cycle: the beat is applied first, then the header.
- Every error event, including a repeat of an already-sticky flag, increments err_cnt_o, saturating at all-ones. Two errors in one cycle count as one.
- err_clr_i clears err_*_o and err_cnt_o. An error in the same cycle as err_clr_i wins and leaves count=1.
- Pixel outputs: 1-cycle latency; registered; all zero when pix_valid_o=0.

Optional Feature:
- Macro: CSI_RX_FRAME_TRACKER_VC_FILTER_EN.
- Defined: headers with vc_i!=VC_ID are ignored entirely, as is payload following such a long header until the next accepted header; no errors are raised.
- Undefined: vc_i is ignored and all packets are tracked as one stream.

Test Plan:
- FS, lp wc=8, 2 beats, FE -> sof/sol on beat 1, eol on beat 2, be=1111 both; line_cnt=1; frame_cnt=1; no errors.
- FS, lp wc=6, 2 beats -> beat 2 be=0011 with eol; a 3rd stray beat -> err_wc=1, err_cnt=1, no pix_valid.
- FE in IDLE, then FS, FS -> err_seq=1, err_cnt=2; line_cnt restarts at 0.
- EXP_LINES=3: FS, 2 lines of wc=4, FE -> err_lines=1; frame_cnt=1.
- lp wc=12, after 1 beat a new lp header arrives -> err_wc=1, no eol, line_cnt=2, new line starts with sol.
- err_cnt saturation (ERR_CNT_W=2): 5 errors -> err_cnt=3; err_clr_i -> all zero. With macro defined, VC_ID=1: a vc=0 frame produces no output and no errors.
